// File: rtl/debounced_counter_pkg.sv
// Shared types and constants for the debounced up/down counter and its button channels.
// Optional feature macro used by the including files: DEBOUNCED_COUNTER_AUTOREPEAT_EN.
package debounced_counter_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } debounce_state_t;

    localparam int CH_UP    = 0;
    localparam int CH_DOWN  = 1;
    localparam int CH_CLEAR = 2;
    localparam int NUM_CH   = 3;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 32'd2) begin
            return 32'd1;
        end else begin
            return unsigned'($clog2(n));
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: synchroniser, four-state debounce FSM and registered press strobe.
// With DEBOUNCED_COUNTER_AUTOREPEAT_EN defined, a held press also emits repeat strobes.
module debounce_channel
    import debounced_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
    ,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic strobe
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    debounce_state_t        state_r;
    debounce_state_t        next_state_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next_s;
    logic                   rise_s;
    logic                   repeat_fire_s;
    logic                   strobe_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
        end
    end

    // Debounce state and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOW;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next state: a wait state counts stable cycles and falls back on any bounce.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = CNT_ZERO;
        case (state_r)
            ST_LOW: begin
                if (sync_s) begin
                    next_state_s = ST_WAIT_HIGH;
                end else begin
                    next_state_s = ST_LOW;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sync_s) begin
                    next_state_s = ST_LOW;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_HIGH;
                end else begin
                    cnt_next_s = cnt_r + CW'(1);
                end
            end
            ST_HIGH: begin
                if (!sync_s) begin
                    next_state_s = ST_WAIT_LOW;
                end else begin
                    next_state_s = ST_HIGH;
                end
            end
            ST_WAIT_LOW: begin
                if (sync_s) begin
                    next_state_s = ST_HIGH;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_LOW;
                end else begin
                    cnt_next_s = cnt_r + CW'(1);
                end
            end
            default: begin
                next_state_s = ST_LOW;
            end
        endcase
    end

`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
    logic level_s;
`endif

    // FSM outputs: the accepted-press event and (optionally) the debounced level.
    always_comb begin
        rise_s = 1'b0;
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
        level_s = 1'b0;
`endif
        case (state_r)
            ST_WAIT_HIGH: begin
                rise_s = sync_s && (cnt_r == CNT_LAST);
            end
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
            ST_HIGH, ST_WAIT_LOW: begin
                level_s = 1'b1;
            end
`endif
            default: begin
                rise_s = 1'b0;
            end
        endcase
    end

`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = cnt_width(RMAX);

    logic [RW-1:0] rep_r;
    logic [RW-1:0] rep_next_s;

    // Repeat timer counts down to the next repeat; it is armed by the press event.
    always_comb begin
        rep_next_s    = {RW{1'b0}};
        repeat_fire_s = 1'b0;
        if (REPEAT_EN && level_s) begin
            if (rep_r == {RW{1'b0}}) begin
                repeat_fire_s = 1'b1;
                rep_next_s    = RW'(REPEAT_PERIOD - 1);
            end else begin
                rep_next_s    = rep_r - RW'(1);
            end
        end else if (REPEAT_EN && rise_s) begin
            rep_next_s = RW'(REPEAT_DELAY - 1);
        end else begin
            rep_next_s = {RW{1'b0}};
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_r <= {RW{1'b0}};
        end else begin
            rep_r <= rep_next_s;
        end
    end
`else
    assign repeat_fire_s = 1'b0;
`endif

    // Registered strobe, high for the single cycle following the event.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_r <= 1'b0;
        end else begin
            strobe_r <= rise_s | repeat_fire_s;
        end
    end

    assign strobe = strobe_r;

endmodule

// File: rtl/debounced_updown_counter.sv
// Three debounced button channels driving a wrap/saturate up/down counter and an LED bus.
// Optional auto-repeat on up/down: define DEBOUNCED_COUNTER_AUTOREPEAT_EN.
module debounced_updown_counter
    import debounced_counter_pkg::*;
#(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2,
    parameter int SATURATE        = 0,
    parameter int LED_ACTIVE_LOW  = 1
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] leds,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [NUM_CH-1:0] btn_s;
    logic [NUM_CH-1:0] strobe_s;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  count_next_s;

    assign btn_s[CH_UP]    = btn_up;
    assign btn_s[CH_DOWN]  = btn_down;
    assign btn_s[CH_CLEAR] = btn_clear;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
            ,
            .REPEAT_EN       (ch != CH_CLEAR),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_channel (
            .clk    (clk),
            .rst    (rst),
            .btn    (btn_s[ch]),
            .strobe (strobe_s[ch])
        );
    end

    // Counter update: clear wins, simultaneous up+down cancel, then up, then down.
    always_comb begin
        count_next_s = count_r;
        if (strobe_s[CH_CLEAR]) begin
            count_next_s = CNT_ZERO;
        end else if (strobe_s[CH_UP] && strobe_s[CH_DOWN]) begin
            count_next_s = count_r;
        end else if (strobe_s[CH_UP]) begin
            if ((SATURATE != 0) && (count_r == CNT_MAX)) begin
                count_next_s = count_r;
            end else begin
                count_next_s = count_r + CNT_ONE;
            end
        end else if (strobe_s[CH_DOWN]) begin
            if ((SATURATE != 0) && (count_r == CNT_ZERO)) begin
                count_next_s = count_r;
            end else begin
                count_next_s = count_r - CNT_ONE;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign leds       = (LED_ACTIVE_LOW != 0) ? ~count_r : count_r;
    assign up_pulse   = strobe_s[CH_UP];
    assign down_pulse = strobe_s[CH_DOWN];
    assign at_max     = (count_r == CNT_MAX);
    assign at_min     = (count_r == CNT_ZERO);

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Bench for debounced_updown_counter: a wrap/active-low and a saturate/active-high instance share stimulus
// and are checked every cycle against a run-length reference model plus directed literal expectations.
module tb_debounced_updown_counter;

    localparam int W    = 4;
    localparam int DC   = 4;
    localparam int SS   = 2;
    localparam int MAXV = 15;
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
    localparam int RD = 10;
    localparam int RP = 3;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_up, btn_down, btn_clear;
    logic [W-1:0] cnt_w, leds_w, cnt_s, leds_s;
    logic         up_w, dn_w, mx_w, mn_w, up_s, dn_s, mx_s, mn_s;

    always #5 clk = ~clk;

    debounced_updown_counter #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .SATURATE(0), .LED_ACTIVE_LOW(1)
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
        , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
    ) dut_wrap (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
        .count(cnt_w), .leds(leds_w), .up_pulse(up_w), .down_pulse(dn_w), .at_max(mx_w), .at_min(mn_w)
    );

    debounced_updown_counter #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .SATURATE(1), .LED_ACTIVE_LOW(0)
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
        , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
    ) dut_sat (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
        .count(cnt_s), .leds(leds_s), .up_pulse(up_s), .down_pulse(dn_s), .at_max(mx_s), .at_min(mn_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a sampled-input delay line, and per channel the accepted level plus the
    // length of the current run of samples disagreeing with it (DC+1 in a row flips the level).
    bit mq [3][SS];
    bit mlvl [3];
    int mrun [3];
    bit mpul [3];
    int mage [3];
    int mcw, mcs;
    bit seen_up, seen_dn, seen_both;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(input bit r, input bit [2:0] raw);
        bit np;
        bit s_now;
        if (r) begin
            for (int ch = 0; ch < 3; ch++) begin
                mlvl[ch] = 1'b0; mrun[ch] = 0; mpul[ch] = 1'b0; mage[ch] = 0;
                for (int k = 0; k < SS; k++) mq[ch][k] = 1'b0;
            end
            mcw = 0;
            mcs = 0;
        end else begin
            if (mpul[2]) begin
                mcw = 0; mcs = 0;
            end else if (mpul[0] && mpul[1]) begin
                mcw = mcw;
            end else if (mpul[0]) begin
                mcw = (mcw + 1) % (MAXV + 1);
                mcs = (mcs < MAXV) ? mcs + 1 : MAXV;
            end else if (mpul[1]) begin
                mcw = (mcw + MAXV) % (MAXV + 1);
                mcs = (mcs > 0) ? mcs - 1 : 0;
            end
            for (int ch = 0; ch < 3; ch++) begin
                s_now = mq[ch][SS-1];
                np = 1'b0;
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
                if (ch != 2 && mlvl[ch]) begin
                    mage[ch]++;
                    if (mage[ch] == RD || (mage[ch] > RD && (mage[ch] - RD) % RP == 0)) np = 1'b1;
                end
`endif
                if (s_now != mlvl[ch]) begin
                    mrun[ch]++;
                    if (mrun[ch] == DC + 1) begin
                        mlvl[ch] = s_now;
                        mrun[ch] = 0;
                        if (s_now) begin
                            np = 1'b1;
                            mage[ch] = 0;
                        end
                    end
                end else begin
                    mrun[ch] = 0;
                end
                mpul[ch] = np;
                for (int k = SS - 1; k > 0; k--) mq[ch][k] = mq[ch][k-1];
                mq[ch][0] = raw[ch];
            end
        end
    endfunction

    function automatic void compare_all();
        check("count_wrap",  32'(cnt_w),  32'(mcw));
        check("leds_wrap",   32'(leds_w), 32'(MAXV - mcw));
        check("up_wrap",     32'(up_w),   32'(mpul[0]));
        check("down_wrap",   32'(dn_w),   32'(mpul[1]));
        check("at_max_wrap", 32'(mx_w),   32'(mcw == MAXV));
        check("at_min_wrap", 32'(mn_w),   32'(mcw == 0));
        check("count_sat",   32'(cnt_s),  32'(mcs));
        check("leds_sat",    32'(leds_s), 32'(mcs));
        check("up_sat",      32'(up_s),   32'(mpul[0]));
        check("down_sat",    32'(dn_s),   32'(mpul[1]));
        check("at_max_sat",  32'(mx_s),   32'(mcs == MAXV));
        check("at_min_sat",  32'(mn_s),   32'(mcs == 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(rst, {btn_clear, btn_down, btn_up});
        @(negedge clk);
        compare_all();
        if (up_w === 1'b1) seen_up = 1'b1;
        if (dn_w === 1'b1) seen_dn = 1'b1;
        if (up_w === 1'b1 && dn_w === 1'b1) seen_both = 1'b1;
    endtask

    task automatic press(input bit u, input bit d, input bit c);
        btn_up = u; btn_down = d; btn_clear = c;
        repeat (8) tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_clear = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        int calm;
        int ups [$];
        int base;
        int exp_offs [8];
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_clear = 1'b0;
        seen_up = 1'b0; seen_dn = 1'b0; seen_both = 1'b0;
        repeat (3) tick();
        check("reset_count", 32'(cnt_w), 32'd0);
        check("reset_leds_active_low", 32'(leds_w), 32'd15);

        // Held press: strobe in cycle 7 only, count steps in cycle 8.
        rst = 1'b0; btn_up = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("t1_up_pulse", 32'(up_w), (j == 7) ? 32'd1 : 32'd0);
            check("t1_count", 32'(cnt_w), (j == 8) ? 32'd1 : 32'd0);
            if (j == 8) check("t1_leds", 32'(leds_w), 32'd14);
        end
        btn_up = 1'b0;
        repeat (10) tick();

        // Bouncing input is rejected.
        for (int k = 0; k < 18; k++) begin
            btn_up = (k < 8) && ((k % 4) < 2);
            tick();
            check("t2_no_pulse", 32'(up_w), 32'd0);
            check("t2_count", 32'(cnt_w), 32'd1);
        end

        // Wrap versus saturate at both ends.
        press(1'b0, 1'b1, 1'b0);
        check("t3_down_to_zero", 32'(cnt_w), 32'd0);
        seen_dn = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        check("t3_wrap_under", 32'(cnt_w), 32'd15);
        check("t3_wrap_at_max", 32'(mx_w), 32'd1);
        check("t3_sat_floor", 32'(cnt_s), 32'd0);
        check("t3_sat_down_pulse", 32'(seen_dn), 32'd1);
        press(1'b1, 1'b0, 1'b0);
        check("t3_wrap_over", 32'(cnt_w), 32'd0);
        check("t3_wrap_at_min", 32'(mn_w), 32'd1);
        check("t3_sat_one", 32'(cnt_s), 32'd1);
        repeat (15) press(1'b1, 1'b0, 1'b0);
        check("t3_sat_ceiling", 32'(cnt_s), 32'd15);
        seen_up = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        check("t3_sat_clamped", 32'(cnt_s), 32'd15);
        check("t3_sat_at_max", 32'(mx_s), 32'd1);
        check("t3_sat_up_pulse", 32'(seen_up), 32'd1);
        check("t3_wrap_zero_again", 32'(cnt_w), 32'd0);

        // Simultaneous up and down cancel; clear dominates.
        seen_both = 1'b0;
        press(1'b1, 1'b1, 1'b0);
        check("t4_both_strobes", 32'(seen_both), 32'd1);
        check("t4_unchanged", 32'(cnt_s), 32'd15);
        repeat (9) press(1'b1, 1'b0, 1'b0);
        check("t4_nine", 32'(cnt_w), 32'd9);
        press(1'b1, 1'b1, 1'b1);
        check("t4_clear_wrap", 32'(cnt_w), 32'd0);
        check("t4_clear_sat", 32'(cnt_s), 32'd0);

        // Reset in the middle of a debounce window.
        repeat (2) press(1'b1, 1'b0, 1'b0);
        btn_up = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("t5_count", 32'(cnt_w), 32'd0);
        check("t5_leds", 32'(leds_w), 32'd15);
        check("t5_no_pulse", 32'(up_w), 32'd0);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("t5_up_pulse", 32'(up_w), (j == 7) ? 32'd1 : 32'd0);
            check("t5_count_after", 32'(cnt_w), (j == 8) ? 32'd1 : 32'd0);
        end
        btn_up = 1'b0;
        repeat (10) tick();

`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
        // Auto-repeat: strobes at +0, +10, +13 ... +28 relative to the press strobe.
        exp_offs = '{0, 10, 13, 16, 19, 22, 25, 28};
        base = int'(cnt_w);
        btn_up = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            if (j == 31) btn_up = 1'b0;
            tick();
            if (up_w === 1'b1) ups.push_back(j);
        end
        check("t6_strobe_count", 32'(ups.size()), 32'd8);
        if (ups.size() == 8) begin
            for (int k = 0; k < 8; k++) check("t6_strobe_offset", 32'(ups[k] - ups[0]), 32'(exp_offs[k]));
        end
        check("t6_count", 32'(cnt_w), 32'((base + 8) % 16));
`endif

        // Randomized phase alternating calm and bouncy button activity.
        calm = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) calm = int'($urandom_range(0, 1));
            if ($urandom_range(0, (calm != 0) ? 19 : 2) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, (calm != 0) ? 19 : 2) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, (calm != 0) ? 39 : 3) == 0) btn_clear = ~btn_clear;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
